decode_stage_hs: RTL and testbench
==================================

Name: decode_stage_hs

Overview:
- Next-generation RV32I decode stage. Takes fetched instructions and splits them into opcode, rs1, rs2, rd, func3, func7 and a sign-extended immediate.
- Adds the following over the current decode stage:
  - a valid/ready handshake on both sides, with a one-entry skid buffer;
  - full RV32I opcode coverage, including SYSTEM and FENCE;
  - illegal-instruction flagging and an instruction-format tag;
  - an XLEN-parametrised immediate and PC path.
- Sits between the fetch stage and the register-read/issue stage.

Parameters:
- XLEN, 32, datapath width of the PC and the immediate. Legal values are 32 and 64. The immediate is sign-extended to XLEN.
- RS_WIDTH, 5, register-specifier width.
- OPCODE_WIDTH, 7, opcode field width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept an instruction. Equals !skid_valid && !flush. Forced to 0 while rst is high.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  PC of in_instr.
- flush  in  1  synchronous pipeline kill.
- out_valid  out  1  decoded payload valid.
- out_ready  in  1  downstream accepts the payload.
- out_opcode  out  OPCODE_WIDTH  instr[6:0].
- out_rs1, out_rs2, out_rd  out  RS_WIDTH  register specifiers. Set to 0 when unused by the format.
- out_func3  out  3  instr[14:12]. Set to 0 when unused.
- out_func7  out  7  instr[31:25]. Used by R-type only; 0 otherwise.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  format tag: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
- out_illegal  out  1  unrecognised opcode, or instr[1:0] != 2'b11.
- out_pc  out  XLEN  PC matching the payload.

Behaviour:
- Reset (asynchronous, while rst is high):
  - out_valid=0, skid_valid=0.
  - Payload outputs set to the NOP form: opcode=0x13, all other fields 0, fmt=1, illegal=0, pc=0.
- Decode is combinational from in_instr. The result is registered, so latency is 1 cycle from accepted input to out_valid.
- Format mapping:
  - R: opcode 0x33.
  - I: opcodes 0x13, 0x03, 0x67, 0x73 (SYSTEM), 0x0F (FENCE).
  - S: 0x23.
  - B: 0x63.
  - U: 0x37, 0x17.
  - J: 0x6F.
- Immediate layouts are the standard RV32I ones. Bit 31 is replicated up to XLEN-1; the U-type immediate is also sign-extended from bit 31 when XLEN=64.
- Illegal instruction handling:
  - out_fmt=7, out_illegal=1.
  - rs1, rs2, rd, func3, func7 and imm are all 0.
  - out_opcode still carries instr[6:0].
- Handshake rules:
  - An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
  - While out_valid && !out_ready, every payload output holds stable.
  - An accepted input goes to the output register if that register is empty or draining this cycle; otherwise it goes to the skid register.
  - When the output register drains and skid_valid=1, the skid entry moves to the output next cycle, and in_ready rises in that same next cycle.
  - Simultaneous accept and drain with an empty skid: the output register reloads, out_valid stays 1, and there is no bubble.
  - Full throughput is 1 instruction/cycle with out_ready held high.
- Flush:
  - flush has priority over everything else.
  - The cycle after flush, out_valid=0 and skid_valid=0, and the payload is set to the NOP form.
  - Any input presented during the flush cycle is dropped; in_ready is 0 in that cycle.
- Ordering is strictly FIFO: the skid entry always leaves before any newer instruction. No instruction is duplicated or lost except by flush.
- Reset asserted mid-transfer clears everything immediately, including the skid buffer. After release, in_ready=1 on the first cycle.

Test Plan:
- ADDI x1,x2,-1: in_instr=0xFFF10093, out_ready=1.
  - Next cycle: out_valid=1, opcode=0x13, rd=1, rs1=2, rs2=0, func3=0, imm=0xFFFFFFFF, fmt=1, illegal=0.
- BEQ x1,x2,-4 (0xFE208EE3), then LUI x5,0x12345 (0x123452B7), back-to-back.
  - BEQ: rs1=1, rs2=2, rd=0, imm=0xFFFFFFFC, fmt=3.
  - LUI: rd=5, imm=0x12345000, fmt=4.
  - Payloads appear on consecutive cycles.
- Backpressure: send three instructions A, B, C with out_ready=0.
  - A is held on the output, B goes to the skid register, and in_ready=0 while C waits.
  - Raise out_ready: A, B, C emerge in order, each with its own PC, and none is lost.
- Illegal: in_instr=0x00000000, then 0x0000007F.
  - Both give illegal=1, fmt=7, imm=0, rd=0.
  - out_opcode is 0x00 and 0x7F respectively.
- Flush with the output and skid both full, with in_valid=1 in the same cycle.
  - Next cycle: out_valid=0, opcode=0x13, in_ready=1.
  - The instruction presented during the flush cycle never appears on the output.
- XLEN=64: ADDI with imm=-1 gives out_imm=0xFFFFFFFFFFFFFFFF. rst pulsed mid-stream gives out_valid=0 immediately (asynchronously).

Source files
------------

// File: rtl/decode_stage_hs.sv
// RV32I decode stage with valid/ready handshake on both sides and a one-entry skid buffer.
// Decoded payloads are registered; flush and reset return the payload to the NOP form.
module decode_stage_hs #(
  parameter int XLEN         = 32,
  parameter int RS_WIDTH     = 5,
  parameter int OPCODE_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic [XLEN-1:0]         in_pc,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OPCODE_WIDTH-1:0] out_opcode,
  output logic [RS_WIDTH-1:0]     out_rs1,
  output logic [RS_WIDTH-1:0]     out_rs2,
  output logic [RS_WIDTH-1:0]     out_rd,
  output logic [2:0]              out_func3,
  output logic [6:0]              out_func7,
  output logic [XLEN-1:0]         out_imm,
  output logic [2:0]              out_fmt,
  output logic                    out_illegal,
  output logic [XLEN-1:0]         out_pc
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  localparam int PW = OPCODE_WIDTH + 3 * RS_WIDTH + 3 + 7 + XLEN + 3 + 1 + XLEN;

  localparam logic [PW-1:0] NOP_PAYLOAD = {
    OPCODE_WIDTH'(7'h13), {3 * RS_WIDTH{1'b0}}, 3'd0, 7'd0,
    {XLEN{1'b0}}, FMT_I, 1'b0, {XLEN{1'b0}}
  };

  logic [2:0]              dec_fmt;
  logic [RS_WIDTH-1:0]     dec_rs1, dec_rs2, dec_rd;
  logic [2:0]              dec_func3;
  logic [6:0]              dec_func7;
  logic [XLEN-1:0]         dec_imm;
  logic [PW-1:0]           dec_payload;

  logic [PW-1:0]           out_q, out_d;
  logic [PW-1:0]           skid_q, skid_d;
  logic                    out_valid_q, out_valid_d;
  logic                    skid_valid_q, skid_valid_d;
  logic                    in_fire;
  logic                    out_free;

  // Opcode classification on instr[6:2]; the low two bits must be 2'b11 for RV32I.
  always_comb begin
    dec_fmt = FMT_ILL;
    if (in_instr[1:0] == 2'b11) begin
      case (in_instr[6:2])
        5'b01100:                                    dec_fmt = FMT_R;
        5'b00100, 5'b00000, 5'b11001, 5'b11100,
        5'b00011:                                    dec_fmt = FMT_I;
        5'b01000:                                    dec_fmt = FMT_S;
        5'b11000:                                    dec_fmt = FMT_B;
        5'b01101, 5'b00101:                          dec_fmt = FMT_U;
        5'b11011:                                    dec_fmt = FMT_J;
        default:                                     dec_fmt = FMT_ILL;
      endcase
    end
  end

  always_comb begin
    dec_rs1   = '0;
    dec_rs2   = '0;
    dec_rd    = '0;
    dec_func3 = '0;
    dec_func7 = '0;
    dec_imm   = '0;
    case (dec_fmt)
      FMT_R: begin
        dec_rs1   = RS_WIDTH'(in_instr[19:15]);
        dec_rs2   = RS_WIDTH'(in_instr[24:20]);
        dec_rd    = RS_WIDTH'(in_instr[11:7]);
        dec_func3 = in_instr[14:12];
        dec_func7 = in_instr[31:25];
      end
      FMT_I: begin
        dec_rs1   = RS_WIDTH'(in_instr[19:15]);
        dec_rd    = RS_WIDTH'(in_instr[11:7]);
        dec_func3 = in_instr[14:12];
        dec_imm   = {{(XLEN-11){in_instr[31]}}, in_instr[30:20]};
      end
      FMT_S: begin
        dec_rs1   = RS_WIDTH'(in_instr[19:15]);
        dec_rs2   = RS_WIDTH'(in_instr[24:20]);
        dec_func3 = in_instr[14:12];
        dec_imm   = {{(XLEN-11){in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
      end
      FMT_B: begin
        dec_rs1   = RS_WIDTH'(in_instr[19:15]);
        dec_rs2   = RS_WIDTH'(in_instr[24:20]);
        dec_func3 = in_instr[14:12];
        dec_imm   = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
      end
      FMT_U: begin
        dec_rd    = RS_WIDTH'(in_instr[11:7]);
        dec_imm   = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'd0};
      end
      FMT_J: begin
        dec_rd    = RS_WIDTH'(in_instr[11:7]);
        dec_imm   = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  assign dec_payload = {OPCODE_WIDTH'(in_instr[6:0]), dec_rs1, dec_rs2, dec_rd,
                        dec_func3, dec_func7, dec_imm, dec_fmt,
                        (dec_fmt == FMT_ILL), in_pc};

  assign in_ready = !rst && !skid_valid_q && !flush;
  assign in_fire  = in_valid && in_ready;
  assign out_free = !out_valid_q || out_ready;

  // The skid entry always refills the output first, which keeps ordering FIFO.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_d        = NOP_PAYLOAD;
      skid_d       = NOP_PAYLOAD;
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_d        = dec_payload;
        out_valid_d  = 1'b1;
      end else begin
        out_valid_d  = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = dec_payload;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= NOP_PAYLOAD;
      skid_q       <= NOP_PAYLOAD;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign {out_opcode, out_rs1, out_rs2, out_rd, out_func3, out_func7,
          out_imm, out_fmt, out_illegal, out_pc} = out_q;

endmodule

// File: tb/tb_decode_stage_hs.sv
// Randomized bench for decode_stage_hs: a queue-based reference model of the handshake
// plus an ISA-level decoder, checked every cycle, with a few hand-computed directed cases.
module tb_decode_stage_hs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] pc64 = '0;

  always #5 clk = ~clk;

  logic        in_ready, out_valid, out_illegal;
  logic [6:0]  out_opcode, out_func7;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_func3, out_fmt;
  logic [31:0] out_imm, out_pc;

  logic        w_in_ready, w_out_valid, w_out_illegal;
  logic [6:0]  w_out_opcode, w_out_func7;
  logic [4:0]  w_out_rs1, w_out_rs2, w_out_rd;
  logic [2:0]  w_out_func3, w_out_fmt;
  logic [63:0] w_out_imm, w_out_pc;

  decode_stage_hs #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(pc64[31:0]), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_func3(out_func3), .out_func7(out_func7), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_illegal(out_illegal), .out_pc(out_pc)
  );

  decode_stage_hs #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_instr(in_instr), .in_pc(pc64), .flush(flush),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_opcode(w_out_opcode),
    .out_rs1(w_out_rs1), .out_rs2(w_out_rs2), .out_rd(w_out_rd),
    .out_func3(w_out_func3), .out_func7(w_out_func7), .out_imm(w_out_imm),
    .out_fmt(w_out_fmt), .out_illegal(w_out_illegal), .out_pc(w_out_pc)
  );

  typedef struct packed {
    logic [6:0]  opc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [63:0] pc;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  bit   nop_chk = 1'b0;
  logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F,
                           7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // ISA-level decode: format from the full opcode, immediate as a signed 64-bit value.
  function automatic exp_t model(input logic [31:0] w, input logic [63:0] pc);
    exp_t e;
    int f;
    longint v;
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    logic signed [19:0] u20;
    logic signed [20:0] j21;
    e = '0;
    e.opc = w[6:0];
    e.pc = pc;
    f = 7;
    if (w[1:0] == 2'b11) begin
      case (w[6:0])
        7'h33: f = 0;
        7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: f = 1;
        7'h23: f = 2;
        7'h63: f = 3;
        7'h37, 7'h17: f = 4;
        7'h6F: f = 5;
        default: f = 7;
      endcase
    end
    v = 0;
    case (f)
      1: begin i12 = w[31:20]; v = i12; end
      2: begin i12 = {w[31:25], w[11:7]}; v = i12; end
      3: begin b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; v = b13; end
      4: begin u20 = w[31:12]; v = longint'(u20) * 4096; end
      5: begin j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; v = j21; end
      default: v = 0;
    endcase
    e.imm = v;
    e.fmt = 3'(f);
    e.ill = (f == 7);
    if (f == 0 || f == 1 || f == 2 || f == 3) begin e.rs1 = w[19:15]; e.f3 = w[14:12]; end
    if (f == 0 || f == 2 || f == 3) e.rs2 = w[24:20];
    if (f == 0 || f == 1 || f == 4 || f == 5) e.rd = w[11:7];
    if (f == 0) e.f7 = w[31:25];
    return e;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 3) != 0) r[6:0] = ops[$urandom_range(0, 10)];
    return r;
  endfunction

  // In flight = accepted but not yet drained; two in flight means the skid entry is occupied.
  always @(negedge clk) begin
    exp_t e;
    bit   exp_ir;
    if (rst) begin
      q.delete();
      nop_chk = 1'b0;
      chk("rst out_valid", 64'(out_valid), 64'd0);
      chk("rst in_ready", 64'(in_ready), 64'd0);
      chk("rst opcode", 64'(out_opcode), 64'h13);
      chk("rst fmt", 64'(out_fmt), 64'd1);
      chk("rst pc", 64'(out_pc), 64'd0);
      chk("rst out_valid64", 64'(w_out_valid), 64'd0);
    end else begin
      exp_ir = (q.size() < 2) && !flush;
      chk("in_ready", 64'(in_ready), 64'(exp_ir));
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("out_valid64", 64'(w_out_valid), 64'(q.size() > 0));
      if (nop_chk) begin
        nop_chk = 1'b0;
        chk("nop opcode", 64'(out_opcode), 64'h13);
        chk("nop rd", 64'(out_rd), 64'd0);
        chk("nop imm", 64'(out_imm), 64'd0);
        chk("nop fmt", 64'(out_fmt), 64'd1);
        chk("nop illegal", 64'(out_illegal), 64'd0);
        chk("nop pc", 64'(out_pc), 64'd0);
      end
      if (q.size() > 0 && out_valid) begin
        e = q[0];
        chk("opcode", 64'(out_opcode), 64'(e.opc));
        chk("rs1", 64'(out_rs1), 64'(e.rs1));
        chk("rs2", 64'(out_rs2), 64'(e.rs2));
        chk("rd", 64'(out_rd), 64'(e.rd));
        chk("func3", 64'(out_func3), 64'(e.f3));
        chk("func7", 64'(out_func7), 64'(e.f7));
        chk("imm", 64'(out_imm), 64'(e.imm[31:0]));
        chk("fmt", 64'(out_fmt), 64'(e.fmt));
        chk("illegal", 64'(out_illegal), 64'(e.ill));
        chk("pc", 64'(out_pc), 64'(e.pc[31:0]));
        chk("imm64", w_out_imm, e.imm);
        chk("pc64", w_out_pc, e.pc);
      end
      if (flush) begin
        q.delete();
        nop_chk = 1'b1;
      end else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_valid && exp_ir) q.push_back(model(in_instr, pc64));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    chk("lit reset out_valid", 64'(out_valid), 64'd0);
    chk("lit reset in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("lit in_ready after reset", 64'(in_ready), 64'd1);

    // ADDI x1,x2,-1
    step(); in_valid = 1'b1; in_instr = 32'hFFF10093; pc64 = 64'h100; out_ready = 1'b1;
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("lit addi valid", 64'(out_valid), 64'd1);
    chk("lit addi opcode", 64'(out_opcode), 64'h13);
    chk("lit addi rd", 64'(out_rd), 64'd1);
    chk("lit addi rs1", 64'(out_rs1), 64'd2);
    chk("lit addi rs2", 64'(out_rs2), 64'd0);
    chk("lit addi imm", 64'(out_imm), 64'hFFFF_FFFF);
    chk("lit addi fmt", 64'(out_fmt), 64'd1);
    chk("lit addi imm64", w_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);

    // BEQ then LUI back-to-back
    step(); in_valid = 1'b1; in_instr = 32'hFE208EE3; pc64 = 64'h200;
    step(); in_instr = 32'h123452B7; pc64 = 64'h204;
    @(negedge clk);
    chk("lit beq rs1", 64'(out_rs1), 64'd1);
    chk("lit beq rs2", 64'(out_rs2), 64'd2);
    chk("lit beq rd", 64'(out_rd), 64'd0);
    chk("lit beq imm", 64'(out_imm), 64'hFFFF_FFFC);
    chk("lit beq fmt", 64'(out_fmt), 64'd3);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("lit lui valid", 64'(out_valid), 64'd1);
    chk("lit lui rd", 64'(out_rd), 64'd5);
    chk("lit lui imm", 64'(out_imm), 64'h1234_5000);
    chk("lit lui fmt", 64'(out_fmt), 64'd4);

    // Backpressure: A on output, B in skid, C waiting
    step(); out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00108093; pc64 = 64'h300;
    step(); in_instr = 32'h00210113; pc64 = 64'h304;
    step(); in_instr = 32'h00318193; pc64 = 64'h308;
    @(negedge clk);
    chk("lit bp in_ready", 64'(in_ready), 64'd0);
    chk("lit bp hold A", 64'(out_pc), 64'h300);
    step();
    @(negedge clk);
    chk("lit bp still A", 64'(out_pc), 64'h300);
    step(); out_ready = 1'b1;
    @(negedge clk);
    chk("lit bp A", 64'(out_pc), 64'h300);
    step();
    @(negedge clk);
    chk("lit bp B", 64'(out_pc), 64'h304);
    chk("lit bp ready again", 64'(in_ready), 64'd1);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("lit bp C", 64'(out_pc), 64'h308);
    chk("lit bp C rd", 64'(out_rd), 64'd3);

    // Illegal words
    step(); in_valid = 1'b1; in_instr = 32'h0000_0000; pc64 = 64'h400;
    step(); in_instr = 32'h0000_007F; pc64 = 64'h404;
    @(negedge clk);
    chk("lit ill0 illegal", 64'(out_illegal), 64'd1);
    chk("lit ill0 fmt", 64'(out_fmt), 64'd7);
    chk("lit ill0 imm", 64'(out_imm), 64'd0);
    chk("lit ill0 opcode", 64'(out_opcode), 64'h00);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("lit ill7f illegal", 64'(out_illegal), 64'd1);
    chk("lit ill7f fmt", 64'(out_fmt), 64'd7);
    chk("lit ill7f rd", 64'(out_rd), 64'd0);
    chk("lit ill7f opcode", 64'(out_opcode), 64'h7F);

    // Flush with output and skid full, input presented in the flush cycle
    step(); out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500293; pc64 = 64'h500;
    step(); in_instr = 32'h00600313; pc64 = 64'h504;
    step(); flush = 1'b1; in_instr = 32'h00700393; pc64 = 64'h508;
    @(negedge clk);
    chk("lit flush in_ready", 64'(in_ready), 64'd0);
    step(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("lit post-flush valid", 64'(out_valid), 64'd0);
    chk("lit post-flush opcode", 64'(out_opcode), 64'h13);
    chk("lit post-flush in_ready", 64'(in_ready), 64'd1);
    step(); step();
    @(negedge clk);
    chk("lit flushed input dropped", 64'(out_valid), 64'd0);

    // Randomized traffic with one asynchronous reset mid-stream
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      in_instr  = rnd_instr();
      pc64      = {$urandom, $urandom};
      if (cyc == 1500) begin
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("lit pre-reset valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("lit async reset valid", 64'(out_valid), 64'd0);
        chk("lit async reset valid64", 64'(w_out_valid), 64'd0);
        @(posedge clk);
        #3 rst = 1'b0;
      end
    end

    step(); in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (5) step();
    @(negedge clk);
    chk("lit drained", 64'(out_valid), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
